hdr_frame_sequencer: RTL and testbench
======================================

# hdr_frame_sequencer

Front-end controller for the HDR merge datapath. It accepts two exposure pixel streams (long and short) over ready/valid, and aligns them to a common frame start. It then issues pixel pairs, with regenerated valid/sop/eop, into the fixed-latency, non-stallable HDR merge pipeline. Issue is gated by a credit count that mirrors free space in the output buffer after the pipeline. Frame geometry mismatches and loss of alignment are detected and recovered by resynchronising on the next start-of-frame.

## Interface
Parameters:
- DATA_WIDTH, 32, width of one colour component; pixels are packed {r,g,b} in 3*DATA_WIDTH bits.
- IMG_W, 1920, pixels per line.
- IMG_H, 1080, lines per frame.
- CREDITS, 32, downstream buffer depth, which is the initial credit count.

Ports:
- clk  in  1  system clock. This block uses one clock.
- rst_n  in  1  reset, asynchronous and active-low.
- enable_i  in  1  level; run the sequencer.
- src0_valid_i / src0_ready_o  in/out  1  handshake for exposure 0 (long).
- src0_data_i  in  3*DATA_WIDTH  pixel for exposure 0.
- src0_sop_i, src0_eop_i  in  1  frame markers for exposure 0.
- src1_valid_i / src1_ready_o / src1_data_i / src1_sop_i / src1_eop_i: same signals for exposure 1 (short).
- credit_return_i  in  1  one pulse per beat popped from the downstream buffer.
- hdr_valid_o, hdr_sop_o, hdr_eop_o  out  1  strobes to the merge pipeline.
- hdr_data0_o, hdr_data1_o  out  3*DATA_WIDTH  paired pixels.
- frame_done_o  out  1  one-cycle pulse with the issued eop beat.
- sync_err_o  out  1  one-cycle pulse on each alignment error.
- err_cnt_o  out  8  saturating alignment-error count.
- busy_o  out  1  high when the state is not IDLE.

## Operation
States are IDLE, SYNC and RUN.
- **IDLE:** both readys are 0. Go to SYNC when enable_i is 1.
- **SYNC:** each source independently pops and discards beats while its head is valid and not sop. The ready for that source is held low once its head shows sop. When both heads are valid and sop, go to RUN with x=y=0.
- **RUN:** a beat fires when src0_valid, src1_valid and credit>0 are all true. Both readys equal fire; ready depends combinationally on both valids and credit.
  - On fire, both beats are registered to hdr_* outputs.
  - hdr_sop_o = (x==0 && y==0).
  - hdr_eop_o = (x==IMG_W-1 && y==IMG_H-1).
  - x wraps at IMG_W-1; y increments on that wrap and wraps at IMG_H-1.
- **Error checks** are evaluated on the fire candidate, before popping.
  - Either head has sop=1 at a position other than (0,0): no pop, no issue, sync_err_o pulses, go to SYNC. The head is kept so SYNC accepts it immediately.
  - Either head has sop=0 at (0,0): no pop, no issue, error, go to SYNC. SYNC discards that beat.
  - Either eop differs from the last-position flag: pop both, no issue, error, go to SYNC.
- **End of frame:** on the eop fire, frame_done_o pulses. If enable_i is 1, stay in RUN at (0,0); otherwise go to IDLE.
- **Disable:** deassertion of enable_i mid-frame has no effect until the frame's eop fires. Deassertion in SYNC goes to IDLE on the next cycle.
- **Credits:** initialised to CREDITS. Decrement on issue, increment on credit_return_i; both in the same cycle leave the count unchanged. The count saturates at CREDITS; extra returns are ignored.
- **Error counter:** err_cnt_o increments on each sync_err_o and saturates at 255.

## Timing
- Reset values:
  - All outputs are 0 (hdr_*, frame_done_o, sync_err_o, err_cnt_o, busy_o, readys).
  - state=IDLE, x=y=0, credit=CREDITS.
- Latency: fire in cycle N gives hdr_valid_o and data in cycle N+1. frame_done_o and sync_err_o are registered and appear in cycle N+1 of the triggering event.
- No backpressure exists on hdr_*. At most CREDITS beats are ever outstanding.
- A credit returned in cycle N allows fire in cycle N+1 when credit was 0.
- Asserting rst_n low mid-frame aborts immediately. After reset, the next frame is acquired only via SYNC.
- With both sources always valid and credit available, throughput is 1 pair per cycle.

## Structure
- Package hdr_pkg holds:
  - the state enum seq_state_t {IDLE, SYNC, RUN};
  - the pixel type pix_t, a logic vector of 3*DATA_WIDTH bits;
  - the localparam widths X_W=$clog2(IMG_W), Y_W=$clog2(IMG_H) and CR_W=$clog2(CREDITS+1).
- Sub-module hdr_credit_counter (inputs: consume, give back; outputs: credit_avail, count) contains the saturating credit logic.
- The FSM, position counters and output register stay in the top module.

## Test plan
All scenarios use IMG_W=4, IMG_H=2 and CREDITS=4.
- **Clean frame:** both sources stream 8 beats with sop on beat 0 and eop on beat 7. Expect 8 hdr_valid_o beats, sop on the first, eop and frame_done_o on the eighth, err_cnt_o=0.
- **Misaligned start:** src1 sends 3 junk beats before its sop. Expect the 3 junk beats popped in SYNC, the first issued pair is both sop beats, and no error.
- **Credit stall:** credit_return_i held at 0. Expect exactly 4 issues, then both readys low. One credit_return_i pulse gives exactly one more issue in the next cycle.
- **Early eop:** src0 eop on beat 5. Expect sync_err_o=1 and err_cnt_o=1. Only 5 beats are issued, with no eop. The next clean frame issues 8 beats.
- **Unexpected sop:** src1 sop at position 2. Expect no pop and an error; after resync, the first issued pair is the src1 sop beat together with the next src0 sop beat.
- **Reset mid-frame:** rst_n low on beat 3 for 2 cycles. Expect all outputs 0 and credit=4. After release, the next frame is issued cleanly from sop.

Source files
------------

// File: rtl/hdr_pkg.sv
// Shared types and default geometry for the HDR frame sequencer.
// Modules derive their own widths from their parameters via cw().
package hdr_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_IMG_W      = 1920;
    localparam int DEF_IMG_H      = 1080;
    localparam int DEF_CREDITS    = 32;

    localparam int X_W  = $clog2(DEF_IMG_W);
    localparam int Y_W  = $clog2(DEF_IMG_H);
    localparam int CR_W = $clog2(DEF_CREDITS + 1);

    typedef logic [3*DEF_DATA_WIDTH-1:0] pix_t;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        RUN
    } seq_state_t;

    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hdr_credit_counter.sv
// Saturating credit count mirroring free slots in the buffer
// behind the merge pipeline.
module hdr_credit_counter
    import hdr_pkg::*;
#(
    parameter int CREDITS = DEF_CREDITS,
    parameter int CW      = $clog2(CREDITS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          consume,
    input  logic          give_back,
    output logic          credit_avail,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] FULL = CW'(CREDITS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= FULL;
        end else if (consume && !give_back) begin
            count <= count - CW'(1);
        end else if (give_back && !consume && count != FULL) begin
            count <= count + CW'(1);
        end
    end

    assign credit_avail = (count != '0);

endmodule

// File: rtl/hdr_frame_sequencer.sv
// Aligns long/short exposure streams on sop and issues credit-gated
// pixel pairs into the non-stallable HDR merge pipeline.
module hdr_frame_sequencer
    import hdr_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int IMG_W      = DEF_IMG_W,
    parameter int IMG_H      = DEF_IMG_H,
    parameter int CREDITS    = DEF_CREDITS
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable_i,
    input  logic                    src0_valid_i,
    output logic                    src0_ready_o,
    input  logic [3*DATA_WIDTH-1:0] src0_data_i,
    input  logic                    src0_sop_i,
    input  logic                    src0_eop_i,
    input  logic                    src1_valid_i,
    output logic                    src1_ready_o,
    input  logic [3*DATA_WIDTH-1:0] src1_data_i,
    input  logic                    src1_sop_i,
    input  logic                    src1_eop_i,
    input  logic                    credit_return_i,
    output logic                    hdr_valid_o,
    output logic                    hdr_sop_o,
    output logic                    hdr_eop_o,
    output logic [3*DATA_WIDTH-1:0] hdr_data0_o,
    output logic [3*DATA_WIDTH-1:0] hdr_data1_o,
    output logic                    frame_done_o,
    output logic                    sync_err_o,
    output logic [7:0]              err_cnt_o,
    output logic                    busy_o
);

    localparam int XW = cw(IMG_W);
    localparam int YW = cw(IMG_H);
    localparam int CW = $clog2(CREDITS + 1);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    seq_state_t    state;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          credit_avail;
    logic [CW-1:0] credit_count;
    logic          at_origin, at_last;
    logic          cand, sop_err, eop_err, pop, issue;
    logic          both_sop;

    hdr_credit_counter #(
        .CREDITS (CREDITS),
        .CW      (CW)
    ) u_credit (
        .clk          (clk),
        .rst_n        (rst_n),
        .consume      (issue),
        .give_back    (credit_return_i),
        .credit_avail (credit_avail),
        .count        (credit_count)
    );

    assign at_origin = (x == '0) && (y == '0);
    assign at_last   = (x == X_LAST) && (y == Y_LAST);
    assign both_sop  = src0_valid_i && src0_sop_i && src1_valid_i && src1_sop_i;

    // Errors are judged on the would-be fire, before anything is popped.
    assign cand    = (state == RUN) && src0_valid_i && src1_valid_i && credit_avail;
    assign sop_err = cand && ((src0_sop_i != at_origin) || (src1_sop_i != at_origin));
    assign eop_err = cand && !sop_err
                   && ((src0_eop_i != at_last) || (src1_eop_i != at_last));
    assign pop     = cand && !sop_err;
    assign issue   = pop && !eop_err;

    always_comb begin
        src0_ready_o = 1'b0;
        src1_ready_o = 1'b0;
        unique case (1'b1)
            state == SYNC: begin
                src0_ready_o = src0_valid_i && !src0_sop_i;
                src1_ready_o = src1_valid_i && !src1_sop_i;
            end
            state == RUN: begin
                src0_ready_o = pop;
                src1_ready_o = pop;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            x            <= '0;
            y            <= '0;
            hdr_valid_o  <= 1'b0;
            hdr_sop_o    <= 1'b0;
            hdr_eop_o    <= 1'b0;
            hdr_data0_o  <= '0;
            hdr_data1_o  <= '0;
            frame_done_o <= 1'b0;
            sync_err_o   <= 1'b0;
            err_cnt_o    <= '0;
        end else begin
            hdr_valid_o  <= issue;
            hdr_sop_o    <= issue && at_origin;
            hdr_eop_o    <= issue && at_last;
            frame_done_o <= issue && at_last;
            sync_err_o   <= sop_err || eop_err;
            if (issue) begin
                hdr_data0_o <= src0_data_i;
                hdr_data1_o <= src1_data_i;
            end
            if ((sop_err || eop_err) && err_cnt_o != 8'hff) begin
                err_cnt_o <= err_cnt_o + 8'd1;
            end
            unique case (state)
                IDLE: begin
                    if (enable_i) state <= SYNC;
                end
                SYNC: begin
                    if (!enable_i) begin
                        state <= IDLE;
                    end else if (both_sop) begin
                        state <= RUN;
                        x     <= '0;
                        y     <= '0;
                    end
                end
                RUN: begin
                    if (sop_err || eop_err) begin
                        state <= SYNC;
                        x     <= '0;
                        y     <= '0;
                    end else if (issue) begin
                        if (x == X_LAST) begin
                            x <= '0;
                            if (at_last) begin
                                y <= '0;
                                if (!enable_i) state <= IDLE;
                            end else begin
                                y <= y + YW'(1);
                            end
                        end else begin
                            x <= x + XW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy_o = (state != IDLE);

    credit_bound: assert property (@(posedge clk) disable iff (!rst_n)
        credit_count <= CW'(CREDITS));

endmodule

// File: tb/tb_hdr_frame_sequencer.sv
// Directed and randomized bench for hdr_frame_sequencer against a
// frame-level model of alignment, resync and credit rules.
module tb_hdr_frame_sequencer;

    localparam int DW = 8;
    localparam int W  = 4;
    localparam int H  = 2;
    localparam int CR = 4;
    localparam int NB = W * H;
    localparam int PW = 3 * DW;

    typedef struct packed {
        logic [PW-1:0] d;
        logic          sop;
        logic          eop;
    } beat_t;

    typedef struct packed {
        logic [PW-1:0] d0;
        logic [PW-1:0] d1;
        logic          sop;
        logic          eop;
    } pair_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable_i;
    logic          src0_valid_i, src0_ready_o, src0_sop_i, src0_eop_i;
    logic [PW-1:0] src0_data_i;
    logic          src1_valid_i, src1_ready_o, src1_sop_i, src1_eop_i;
    logic [PW-1:0] src1_data_i;
    logic          credit_return_i;
    logic          hdr_valid_o, hdr_sop_o, hdr_eop_o;
    logic [PW-1:0] hdr_data0_o, hdr_data1_o;
    logic          frame_done_o, sync_err_o, busy_o;
    logic [7:0]    err_cnt_o;

    always #5 clk = ~clk;

    hdr_frame_sequencer #(
        .DATA_WIDTH (DW),
        .IMG_W      (W),
        .IMG_H      (H),
        .CREDITS    (CR)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable_i        (enable_i),
        .src0_valid_i    (src0_valid_i),
        .src0_ready_o    (src0_ready_o),
        .src0_data_i     (src0_data_i),
        .src0_sop_i      (src0_sop_i),
        .src0_eop_i      (src0_eop_i),
        .src1_valid_i    (src1_valid_i),
        .src1_ready_o    (src1_ready_o),
        .src1_data_i     (src1_data_i),
        .src1_sop_i      (src1_sop_i),
        .src1_eop_i      (src1_eop_i),
        .credit_return_i (credit_return_i),
        .hdr_valid_o     (hdr_valid_o),
        .hdr_sop_o       (hdr_sop_o),
        .hdr_eop_o       (hdr_eop_o),
        .hdr_data0_o     (hdr_data0_o),
        .hdr_data1_o     (hdr_data1_o),
        .frame_done_o    (frame_done_o),
        .sync_err_o      (sync_err_o),
        .err_cnt_o       (err_cnt_o),
        .busy_o          (busy_o)
    );

    beat_t q0[$], q1[$];
    pair_t got[$], exp_q[$];
    int    got_cyc[$];
    int    exp_err, err_seen, fd_seen, buffer, vprob, rprob, cyc;
    bit    ret_now, last_r0, last_r1;
    int    vectors = 0;
    int    miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push_frame(input int src, input int n, input int eop_at);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.d   = PW'($urandom());
            b.sop = (i == 0);
            b.eop = (i == eop_at);
            if (src == 0) q0.push_back(b);
            else q1.push_back(b);
        end
    endtask

    task automatic push_junk(input int src, input int n);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.d   = PW'($urandom());
            b.sop = 1'b0;
            b.eop = 1'b0;
            if (src == 0) q0.push_back(b);
            else q1.push_back(b);
        end
    endtask

    // Frame-level rules: drop to sop, walk NB positions, any marker
    // disagreement is one error and a resync.
    task automatic model();
        beat_t a[$], b[$];
        beat_t ha, hb;
        pair_t e;
        int    p;
        bit    running;
        a = q0;
        b = q1;
        exp_q.delete();
        exp_err = 0;
        p = 0;
        running = 0;
        forever begin
            if (!running) begin
                while (a.size() > 0 && !a[0].sop) ha = a.pop_front();
                while (b.size() > 0 && !b[0].sop) hb = b.pop_front();
                if (a.size() == 0 || b.size() == 0) break;
                running = 1;
                p = 0;
            end
            if (a.size() == 0 || b.size() == 0) break;
            if (a[0].sop != (p == 0) || b[0].sop != (p == 0)) begin
                exp_err++;
                running = 0;
                continue;
            end
            ha = a.pop_front();
            hb = b.pop_front();
            if (ha.eop != (p == NB - 1) || hb.eop != (p == NB - 1)) begin
                exp_err++;
                running = 0;
                continue;
            end
            e.d0  = ha.d;
            e.d1  = hb.d;
            e.sop = (p == 0);
            e.eop = (p == NB - 1);
            exp_q.push_back(e);
            p = (p == NB - 1) ? 0 : p + 1;
        end
    endtask

    task automatic cycle();
        beat_t h0, h1;
        pair_t g;
        bit    p0, p1, cr;
        h0 = (q0.size() > 0) ? q0[0] : '0;
        h1 = (q1.size() > 0) ? q1[0] : '0;
        src0_valid_i    = (q0.size() > 0) && ($urandom_range(99) < vprob);
        src1_valid_i    = (q1.size() > 0) && ($urandom_range(99) < vprob);
        src0_data_i     = h0.d;
        src0_sop_i      = h0.sop;
        src0_eop_i      = h0.eop;
        src1_data_i     = h1.d;
        src1_sop_i      = h1.sop;
        src1_eop_i      = h1.eop;
        credit_return_i = ret_now || (buffer > 0 && $urandom_range(99) < rprob);
        #1;
        p0      = src0_valid_i && src0_ready_o;
        p1      = src1_valid_i && src1_ready_o;
        last_r0 = src0_ready_o;
        last_r1 = src1_ready_o;
        cr      = credit_return_i;
        @(posedge clk);
        if (p0) h0 = q0.pop_front();
        if (p1) h1 = q1.pop_front();
        if (cr && buffer > 0) buffer--;
        #1;
        if (hdr_valid_o) begin
            g.d0  = hdr_data0_o;
            g.d1  = hdr_data1_o;
            g.sop = hdr_sop_o;
            g.eop = hdr_eop_o;
            got.push_back(g);
            got_cyc.push_back(cyc);
            buffer++;
            chk("credit_bound", 64'(buffer <= CR), 64'd1);
        end
        if (sync_err_o) err_seen++;
        if (frame_done_o) fd_seen++;
        if (frame_done_o || (hdr_valid_o && hdr_eop_o))
            chk("frame_done", 64'(frame_done_o), 64'(hdr_valid_o && hdr_eop_o));
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        ret_now = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cycle();
            chk("rst_flags", {hdr_valid_o, hdr_sop_o, hdr_eop_o, frame_done_o,
                sync_err_o, busy_o, last_r0, last_r1}, 64'd0);
            chk("rst_data", {hdr_data0_o, hdr_data1_o}, 64'd0);
            chk("rst_err_cnt", err_cnt_o, 64'd0);
            chk("rst_credit", dut.credit_count, 64'(CR));
        end
        rst_n  = 1'b1;
        buffer = 0;
    endtask

    task automatic start_scn();
        model();
        got.delete();
        got_cyc.delete();
        err_seen = 0;
        fd_seen  = 0;
    endtask

    task automatic finish_scn(input string tag);
        int n, eops;
        n = 0;
        while (got.size() < exp_q.size() && n < 1000) begin
            cycle();
            n++;
        end
        repeat (6) cycle();
        chk({tag, "_len"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i < got.size())
                chk($sformatf("%s_beat%0d", tag, i), got[i], exp_q[i]);
        eops = 0;
        foreach (exp_q[i]) if (exp_q[i].eop) eops++;
        chk({tag, "_sync_err"}, err_seen, exp_err);
        chk({tag, "_err_cnt"}, err_cnt_o, exp_err);
        chk({tag, "_frame_done"}, fd_seen, eops);
    endtask

    initial begin
        rst_n = 1'b0;
        enable_i = 1'b0;
        {src0_valid_i, src0_sop_i, src0_eop_i, src1_valid_i} = '0;
        {src1_sop_i, src1_eop_i, credit_return_i} = '0;
        src0_data_i = '0;
        src1_data_i = '0;
        vprob = 100;
        rprob = 100;
        buffer = 0;
        cyc = 0;
        ret_now = 0;
        @(negedge clk);

        // disable while syncing drops back to idle
        do_reset();
        enable_i = 1'b1;
        cycle();
        chk("sync_busy", busy_o, 1);
        enable_i = 1'b0;
        cycle();
        chk("sync_disable", busy_o, 0);
        enable_i = 1'b1;

        // clean frame at full rate
        do_reset();
        vprob = 100;
        rprob = 100;
        push_frame(0, NB, NB - 1);
        push_frame(1, NB, NB - 1);
        start_scn();
        finish_scn("clean");
        if (got_cyc.size() >= NB)
            chk("clean_tput", got_cyc[NB-1] - got_cyc[0], NB - 1);

        // misaligned start: src1 junk popped in SYNC
        do_reset();
        vprob = 85;
        rprob = 70;
        push_junk(1, 3);
        push_frame(0, NB, NB - 1);
        push_frame(1, NB, NB - 1);
        start_scn();
        finish_scn("misalign");
        chk("misalign_q1_empty", q1.size(), 0);

        // credit stall and single-credit release
        do_reset();
        vprob = 100;
        rprob = 0;
        push_frame(0, NB, NB - 1);
        push_frame(1, NB, NB - 1);
        start_scn();
        repeat (12) cycle();
        chk("stall_issued", got.size(), CR);
        chk("stall_readys", {last_r0, last_r1}, 0);
        ret_now = 1'b1;
        cycle();
        ret_now = 1'b0;
        cycle();
        chk("release_ready", {last_r0, last_r1}, 2'b11);
        chk("release_issued", got.size(), CR + 1);
        cycle();
        chk("release_once", got.size(), CR + 1);
        rprob = 50;
        finish_scn("stall");

        // early eop on src0
        do_reset();
        vprob = 80;
        rprob = 70;
        push_frame(0, 6, 5);
        push_frame(1, NB, NB - 1);
        push_frame(0, NB, NB - 1);
        push_frame(1, NB, NB - 1);
        start_scn();
        finish_scn("early_eop");

        // unexpected sop on src1 at position 2
        do_reset();
        push_frame(0, NB, NB - 1);
        push_frame(1, 2, -1);
        push_frame(1, NB, NB - 1);
        push_frame(0, NB, NB - 1);
        start_scn();
        finish_scn("unexp_sop");

        // reset mid-frame, then reacquire via SYNC
        do_reset();
        vprob = 100;
        rprob = 100;
        for (int f = 0; f < 2; f++) begin
            push_frame(0, NB, NB - 1);
            push_frame(1, NB, NB - 1);
        end
        start_scn();
        for (int n = 0; n < 50 && got.size() < 3; n++) cycle();
        chk("pre_reset_issued", got.size(), 3);
        do_reset();
        start_scn();
        finish_scn("mid_reset");

        // randomized frames with stray beats
        for (int r = 0; r < 4; r++) begin
            do_reset();
            vprob = $urandom_range(40, 100);
            rprob = $urandom_range(30, 100);
            for (int f = 0; f < 4; f++) begin
                if ($urandom_range(3) == 0)
                    push_junk($urandom_range(1), $urandom_range(1, 3));
                push_frame(0, NB, NB - 1);
                push_frame(1, NB, NB - 1);
            end
            start_scn();
            finish_scn($sformatf("rand%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
